sprite_line_scheduler: RTL
==========================

// Module: sprite_line_scheduler
// PURPOSE
//  Per-scanline sprite scheduler and shared-ROM sequencer for the sprite path.
//  During h-blank it scans an N_SPR-entry sprite table and picks up to SLOTS
//  sprites that intersect the next line. During active video it resolves which
//  slot owns each pixel and drives one shared sprite ROM with (rom_id, x_pix, y_pix).
//  It returns keyed RGB plus enable to the VGA mixer.
// PARAMETERS
//  N_SPR  8          sprite table entries (power of 2, >=2)
//  SLOTS  4          max sprites drawn per line (1..N_SPR)
//  SPR_W  32         sprite width, pixels
//  SPR_H  32         sprite height, lines
//  KEY    24'hFF00FF transparent colour {R,G,B}
// PORTS
//  clk        in   1   pixel clock
//  rst        in   1   asynchronous active-high reset
//  wr_en      in   1   sprite table write strobe
//  wr_idx     in   log2(N_SPR) table entry written
//  wr_x       in   10  sprite left x
//  wr_y       in   10  sprite top y
//  wr_act     in   1   entry active flag
//  line_start in   1   1-cycle pulse at h-blank start; begins scan for next_y
//  next_y     in   10  line number to be drawn next
//  pix_valid  in   1   vga_x is in the active region
//  vga_x      in   10  current pixel x
//  rom_id     out  log2(N_SPR) sprite index to ROM
//  x_pix      out  10  column within sprite
//  y_pix      out  10  row within sprite
//  R_pix,G_pix,B_pix in 8 each  ROM data, valid 1 clk after address
//  R,G,B      out  8 each  sprite colour
//  enable     out  1   sprite pixel present (not transparent)
//  scan_busy  out  1   scan in progress
//  overflow   out  1   more than SLOTS sprites hit on the last scanned line
// BEHAVIOUR
//  Reset: all table entries inactive, x/y 0; live and shadow slots empty.
//   FSM IDLE; all outputs 0.
//  Table write: takes effect the next cycle. A scan reading the same entry in the
//   write cycle sees the old value.
//  FSM IDLE->SCAN on line_start: clear shadow slots and count, clear overflow, set line_y=next_y.
//  SCAN: evaluate entry idx = 0..N_SPR-1, one per clk.
//   Hit = act && line_y>=y && line_y<y+SPR_H, compared in 11 bits with no wrap.
//   On hit with count<SLOTS: store {idx,x,line_y-y} in the shadow slot[count], count++.
//   On hit with count==SLOTS: set overflow; the entry is dropped.
//  SCAN->COMMIT after entry N_SPR-1. COMMIT (1 clk): live slots <= shadow.
//   Then ->IDLE. scan_busy=1 in SCAN and COMMIT: N_SPR+1 clks total.
//  line_start during SCAN/COMMIT restarts the scan at idx 0. Live slots stay unchanged.
//  Integration constraint: line_start arrives >=N_SPR+1 clks before active video.
//  Pixel pipe (independent of FSM), for each cycle T:
//   T:   match slot s if pix_valid && vga_x>=x_s && vga_x<x_s+SPR_W (11-bit). Lowest s wins.
//   T+1: rom_id, x_pix=vga_x-x_s, y_pix=row_s registered; hit1 registered. On no hit, address holds.
//   T+2: ROM data arrives; R,G,B <= R_pix,G_pix,B_pix.
//        enable <= hit1 && {R_pix,G_pix,B_pix}!=KEY.
//  Latency vga_x -> R,G,B/enable = 2 clks. Off-hit cycles give enable=0, RGB=0.
//  Priority = lower table index, since slots fill in index order.
//  Sprite at x>=1024-SPR_W: pixels past x=1023 are never matched.
// TESTING
//  1. Reset mid-scan (assert rst at idx 3) -> scan_busy=0, enable=0, overflow=0 next edge.
//  2. Entry0 {x=100,y=50,act}; line_start next_y=60; vga_x sweep.
//     -> scan_busy 9 clks; enable 2 clks after vga_x=100..131 only; x_pix 0..31, y_pix=10.
//  3. Entries 0..5 all act, y=0; next_y=0 -> slots hold idx 0..3; overflow=1.
//     Next line_start with next_y=40 -> overflow=0.
//  4. Entry1 x=10, entry2 x=20, both on line; vga_x=25 -> rom_id=1; vga_x=45 -> rom_id=2.
//  5. ROM returns FF00FF for a hit pixel -> enable=0; 123456 -> R=12,G=34,B=56, enable=1.
//  6. Boundaries: y=50 checked on lines 49/50/81/82 -> hits only on 50 and 81.
//     line_start re-pulsed at idx 4 -> scan restarts, total 9 clks from the second pulse.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
//   Per-scanline sprite scheduler and shared sprite-ROM sequencer.
//   During h-blank it walks the sprite table, one entry per clock, and latches
//   up to SLOTS sprites that intersect the next line into shadow slots. The
//   shadow slots are copied to the live slots in one commit cycle. During
//   active video the live slots are searched for the pixel owner. The lowest
//   slot, which is also the lowest table index, wins. The owner drives the
//   shared ROM address, and the returned colour is keyed against KEY.
// Ports
//   clk, rst                    pixel clock, async active-high reset
//   wr_en/wr_idx/wr_x/wr_y/wr_act   sprite table write port
//   line_start, next_y          start a scan for line next_y
//   pix_valid, vga_x            current pixel position (active region)
//   rom_id, x_pix, y_pix        registered ROM address (holds on no hit)
//   R_pix, G_pix, B_pix         ROM data, valid one clock after the address
//   R, G, B, enable             keyed sprite colour, 2 clocks after vga_x
//   scan_busy, overflow         scan status
module sprite_line_scheduler #(
   parameter int          N_SPR = 8,
   parameter int          SLOTS = 4,
   parameter int          SPR_W = 32,
   parameter int          SPR_H = 32,
   parameter logic [23:0] KEY   = 24'hFF00FF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(N_SPR)-1:0] wr_idx,
   input  logic [9:0]               wr_x,
   input  logic [9:0]               wr_y,
   input  logic                     wr_act,
   input  logic                     line_start,
   input  logic [9:0]               next_y,
   input  logic                     pix_valid,
   input  logic [9:0]               vga_x,
   output logic [$clog2(N_SPR)-1:0] rom_id,
   output logic [9:0]               x_pix,
   output logic [9:0]               y_pix,
   input  logic [7:0]               R_pix,
   input  logic [7:0]               G_pix,
   input  logic [7:0]               B_pix,
   output logic [7:0]               R,
   output logic [7:0]               G,
   output logic [7:0]               B,
   output logic                     enable,
   output logic                     scan_busy,
   output logic                     overflow
);
   localparam int IW = $clog2(N_SPR);
   localparam int CW = $clog2(SLOTS + 1);
   localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_COMMIT = 2'd2} state_t;

   // sprite table
   logic [9:0]       tbl_x_q [N_SPR];
   logic [9:0]       tbl_y_q [N_SPR];
   logic [N_SPR-1:0] tbl_act_q;
   logic [9:0]       tbl_x_d [N_SPR];
   logic [9:0]       tbl_y_d [N_SPR];
   logic [N_SPR-1:0] tbl_act_d;

   // scan control and slots
   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [9:0]      line_y_q, line_y_d;
   logic            ovf_q, ovf_d;
   logic            scan_busy_q, scan_busy_d;
   logic [SLOTS-1:0] sh_vld_q, sh_vld_d, lv_vld_q, lv_vld_d;
   logic [IW-1:0]   sh_idx_q [SLOTS];
   logic [IW-1:0]   sh_idx_d [SLOTS];
   logic [IW-1:0]   lv_idx_q [SLOTS];
   logic [IW-1:0]   lv_idx_d [SLOTS];
   logic [9:0]      sh_x_q [SLOTS];
   logic [9:0]      sh_x_d [SLOTS];
   logic [9:0]      lv_x_q [SLOTS];
   logic [9:0]      lv_x_d [SLOTS];
   logic [9:0]      sh_row_q [SLOTS];
   logic [9:0]      sh_row_d [SLOTS];
   logic [9:0]      lv_row_q [SLOTS];
   logic [9:0]      lv_row_d [SLOTS];

   // pixel pipe
   logic [SLOTS-1:0] in_rng_s;
   logic [SW-1:0]    sel_s;
   logic             pix_hit_s;
   logic [IW-1:0]    rom_id_q, rom_id_d;
   logic [9:0]       x_pix_q, x_pix_d, y_pix_q, y_pix_d;
   logic             hit1_q;
   logic [23:0]      rgb_q, rgb_d;
   logic             enable_q, enable_d;

   // Entry under scan; the 11-bit compare keeps y+SPR_H from wrapping past 1023.
   logic [9:0] ent_y_s;
   logic       ent_hit_s;
   logic [9:0] ent_row_s;
   assign ent_y_s   = tbl_y_q[idx_q];
   assign ent_hit_s = tbl_act_q[idx_q] && ({1'b0, line_y_q} >= {1'b0, ent_y_s}) &&
                      ({1'b0, line_y_q} < ({1'b0, ent_y_s} + 11'(SPR_H)));
   assign ent_row_s = line_y_q - ent_y_s;

   // Table write: new value becomes visible to the scan on the following cycle.
   always_comb begin
      for (int i = 0; i < N_SPR; i++) begin
         tbl_x_d[i]   = (wr_en && (wr_idx == IW'(i))) ? wr_x   : tbl_x_q[i];
         tbl_y_d[i]   = (wr_en && (wr_idx == IW'(i))) ? wr_y   : tbl_y_q[i];
         tbl_act_d[i] = (wr_en && (wr_idx == IW'(i))) ? wr_act : tbl_act_q[i];
      end
   end

   // Scan FSM next state: line_start always restarts, live slots only change in COMMIT.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      line_y_d = line_y_q;
      ovf_d    = ovf_q;
      sh_vld_d = sh_vld_q;
      lv_vld_d = lv_vld_q;
      for (int s = 0; s < SLOTS; s++) begin
         sh_idx_d[s] = sh_idx_q[s];
         sh_x_d[s]   = sh_x_q[s];
         sh_row_d[s] = sh_row_q[s];
         lv_idx_d[s] = lv_idx_q[s];
         lv_x_d[s]   = lv_x_q[s];
         lv_row_d[s] = lv_row_q[s];
      end
      if (line_start) begin
         state_d  = ST_SCAN;
         idx_d    = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
         line_y_d = next_y;
         sh_vld_d = '0;
      end else begin
         case (state_q)
            ST_SCAN: begin
               if (ent_hit_s && (cnt_q < CW'(SLOTS))) begin
                  for (int s = 0; s < SLOTS; s++) begin
                     sh_vld_d[s] = (cnt_q == CW'(s)) ? 1'b1           : sh_vld_q[s];
                     sh_idx_d[s] = (cnt_q == CW'(s)) ? idx_q          : sh_idx_q[s];
                     sh_x_d[s]   = (cnt_q == CW'(s)) ? tbl_x_q[idx_q] : sh_x_q[s];
                     sh_row_d[s] = (cnt_q == CW'(s)) ? ent_row_s      : sh_row_q[s];
                  end
                  cnt_d = cnt_q + CW'(1);
               end else if (ent_hit_s) begin
                  ovf_d = 1'b1;
               end else begin
                  ovf_d = ovf_q;
               end
               if (idx_q == IW'(N_SPR - 1)) begin
                  state_d = ST_COMMIT;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
            ST_COMMIT: begin
               lv_vld_d = sh_vld_q;
               for (int s = 0; s < SLOTS; s++) begin
                  lv_idx_d[s] = sh_idx_q[s];
                  lv_x_d[s]   = sh_x_q[s];
                  lv_row_d[s] = sh_row_q[s];
               end
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      scan_busy_d = (state_d != ST_IDLE);
   end

   // Table, scan FSM and slot registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_SPR; i++) begin
            tbl_x_q[i] <= 10'd0;
            tbl_y_q[i] <= 10'd0;
         end
         tbl_act_q   <= '0;
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         line_y_q    <= 10'd0;
         ovf_q       <= 1'b0;
         scan_busy_q <= 1'b0;
         sh_vld_q    <= '0;
         lv_vld_q    <= '0;
         for (int s = 0; s < SLOTS; s++) begin
            sh_idx_q[s] <= '0;
            sh_x_q[s]   <= 10'd0;
            sh_row_q[s] <= 10'd0;
            lv_idx_q[s] <= '0;
            lv_x_q[s]   <= 10'd0;
            lv_row_q[s] <= 10'd0;
         end
      end else begin
         tbl_x_q     <= tbl_x_d;
         tbl_y_q     <= tbl_y_d;
         tbl_act_q   <= tbl_act_d;
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         line_y_q    <= line_y_d;
         ovf_q       <= ovf_d;
         scan_busy_q <= scan_busy_d;
         sh_vld_q    <= sh_vld_d;
         lv_vld_q    <= lv_vld_d;
         sh_idx_q    <= sh_idx_d;
         sh_x_q      <= sh_x_d;
         sh_row_q    <= sh_row_d;
         lv_idx_q    <= lv_idx_d;
         lv_x_q      <= lv_x_d;
         lv_row_q    <= lv_row_d;
      end
   end

   // Per-slot horizontal match; vga_x is 10 bits, so nothing past x=1023 can match.
   always_comb begin
      in_rng_s = '0;
      for (int s = 0; s < SLOTS; s++) begin
         in_rng_s[s] = pix_valid && lv_vld_q[s] && ({1'b0, vga_x} >= {1'b0, lv_x_q[s]}) &&
                       ({1'b0, vga_x} < ({1'b0, lv_x_q[s]} + 11'(SPR_W)));
      end
   end

   // Owner select (lowest slot wins), ROM address and keyed colour stage.
   always_comb begin
      sel_s = '0;
      for (int s = SLOTS - 1; s >= 0; s--) begin
         sel_s = in_rng_s[s] ? SW'(s) : sel_s;
      end
      pix_hit_s = |in_rng_s;
      rom_id_d  = pix_hit_s ? lv_idx_q[sel_s]          : rom_id_q;
      x_pix_d   = pix_hit_s ? (vga_x - lv_x_q[sel_s])  : x_pix_q;
      y_pix_d   = pix_hit_s ? lv_row_q[sel_s]          : y_pix_q;
      enable_d  = hit1_q && ({R_pix, G_pix, B_pix} != KEY);
      rgb_d     = enable_d ? {R_pix, G_pix, B_pix} : 24'd0;
   end

   // Pixel pipeline registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_id_q <= '0;
         x_pix_q  <= 10'd0;
         y_pix_q  <= 10'd0;
         hit1_q   <= 1'b0;
         rgb_q    <= 24'd0;
         enable_q <= 1'b0;
      end else begin
         rom_id_q <= rom_id_d;
         x_pix_q  <= x_pix_d;
         y_pix_q  <= y_pix_d;
         hit1_q   <= pix_hit_s;
         rgb_q    <= rgb_d;
         enable_q <= enable_d;
      end
   end

   assign rom_id    = rom_id_q;
   assign x_pix     = x_pix_q;
   assign y_pix     = y_pix_q;
   assign R         = rgb_q[23:16];
   assign G         = rgb_q[15:8];
   assign B         = rgb_q[7:0];
   assign enable    = enable_q;
   assign scan_busy = scan_busy_q;
   assign overflow  = ovf_q;

endmodule
